// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 74HC595 display chain: one digit per refresh slot, hex-decoded into a
// {seg_byte, dig_sel_byte} frame and handed to the serial shifter over start/busy/done.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIG     = 8,
  parameter int unsigned REFRESH_CNT = 50000,
  parameter int unsigned TIMEOUT     = 1024,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [4*NUM_DIG-1:0] disp_data,
  input  logic [NUM_DIG-1:0]   dp_mask,
  input  logic [NUM_DIG-1:0]   blank_mask,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 tx_start,
  output logic [15:0]          tx_frame,
  output logic [2:0]           dig_idx,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int unsigned CntW = $clog2(REFRESH_CNT);
  localparam int unsigned ToW  = $clog2(TIMEOUT);
  localparam logic [2:0]  LastDig  = 3'(NUM_DIG - 1);
  localparam logic [15:0] OffFrame = {(SEG_ACT_LOW ? 8'hFF : 8'h00),
                                      (DIG_ACT_LOW ? 8'hFF : 8'h00)};

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StWaitDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] tick_cnt_q;
  logic [ToW-1:0]  to_cnt_q;
  logic            tick;
  logic [2:0]      next_idx;

  // Masks and nibbles widened to a full 8-digit map so a 3-bit index always selects in range.
  logic [31:0]     disp32;
  logic [7:0]      dp8;
  logic [7:0]      blank8;
  logic [3:0]      nib;
  logic [7:0]      seg_raw;
  logic [7:0]      dig_raw;
  logic [15:0]     load_frame;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign disp32   = 32'(disp_data);
  assign dp8      = 8'(dp_mask);
  assign blank8   = 8'(blank_mask);
  assign tick     = en && (tick_cnt_q == CntW'(REFRESH_CNT - 1));
  assign tx_start = (state_q == StSend) && !tx_busy;
  assign next_idx = (dig_idx == LastDig) ? 3'd0 : dig_idx + 3'd1;

  always_comb begin
    nib        = disp32[{dig_idx, 2'b00} +: 4];
    seg_raw    = blank8[dig_idx] ? 8'h00 : {dp8[dig_idx], hex7(nib)};
    dig_raw    = 8'h01 << dig_idx;
    load_frame = {(SEG_ACT_LOW ? ~seg_raw : seg_raw), (DIG_ACT_LOW ? ~dig_raw : dig_raw)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      to_cnt_q    <= '0;
      dig_idx     <= 3'd0;
      tx_frame    <= OffFrame;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (!en || tick) begin
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end

      // Ticks are never queued; a tick landing mid-transfer is only flagged.
      if (tick && (state_q != StIdle)) begin
        overrun <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (tick) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          tx_frame <= load_frame;
          state_q  <= StSend;
        end
        StSend: begin
          if (!tx_busy) begin
            to_cnt_q <= '0;
            state_q  <= StWaitDone;
          end
        end
        StWaitDone: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (tx_done) begin
            dig_idx <= next_idx;
            state_q <= StIdle;
          end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            dig_idx     <= next_idx;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
